// File: rtl/fiber_pkg.sv
// Shared definitions for the fiber cache bank and its request dispatcher.
package fiber_pkg;

   localparam logic [3:0] FETCH_REQ   = 4'b0001;
   localparam logic [3:0] READ_REQ    = 4'b0010;
   localparam logic [3:0] WRITE_REQ   = 4'b0100;
   localparam logic [3:0] CONSUME_REQ = 4'b1000;

   localparam int unsigned FIBER_DATA_W = 16;
   localparam int unsigned FIBER_ADDR_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_RECV = 2'd2,
      ST_RESP = 2'd3
   } fiber_state_e;

   // Canonical request layout at the default bank widths.
   typedef struct packed {
      logic [3:0]              req_type;
      logic [FIBER_ADDR_W-1:0] addr;
      logic [FIBER_DATA_W-1:0] data;
   } fiber_req_t;

   function automatic logic is_onehot4(input logic [3:0] t);
      return (t != 4'b0000) && ((t & (t - 4'd1)) == 4'b0000);
   endfunction

   function automatic logic is_send_type(input logic [3:0] t);
      return (t == FETCH_REQ) || (t == WRITE_REQ);
   endfunction

endpackage

// File: rtl/fiber_req_fifo.sv
// In-order request FIFO; head entry is presented combinationally on rdata.
module fiber_req_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fiber_bank_dispatch.sv
// Queues requests for one fiber cache bank and issues them one at a time,
// driving the insert handshake or collecting read data into a response.
module fiber_bank_dispatch
   import fiber_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [3:0]            i_req_type,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_data,
   output logic [3:0]            o_bank_request_type,
   output logic [ADDR_WIDTH-1:0] o_bank_addr,
   output logic [DATA_WIDTH-1:0] o_bank_data,
   output logic                  o_bank_data_valid,
   input  logic                  i_bank_data_ready,
   input  logic [DATA_WIDTH-1:0] i_bank_rdata,
   input  logic                  i_bank_rdata_valid,
   output logic                  o_bank_rdata_ready,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [3:0]            o_rsp_type,
   output logic [DATA_WIDTH-1:0] o_rsp_data,
   output logic [15:0]           o_illegal_count
);

   typedef struct packed {
      logic [3:0]            req_type;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } req_t;

   req_t                  in_req;
   req_t                  head_req;
   req_t                  active_q;
   fiber_state_e          state_q;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  req_fire;
   logic                  legal;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic [15:0]           illegal_q;

   assign o_req_ready = !fifo_full;
   assign req_fire    = i_req_valid && !fifo_full;
   assign legal       = is_onehot4(i_req_type);
   assign push        = req_fire && legal;
   assign pop         = (state_q == ST_IDLE) && !fifo_empty;
   assign in_req      = {i_req_type, i_req_addr, i_req_data};

   fiber_req_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(req_t))
   ) u_fifo (
      .clk   (i_clk),
      .rst   (i_reset),
      .push  (push),
      .wdata (in_req),
      .pop   (pop),
      .rdata (head_req),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         active_q   <= '0;
         rsp_data_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (!fifo_empty) begin
               active_q <= head_req;
               state_q  <= is_send_type(head_req.req_type) ? ST_SEND : ST_RECV;
            end
            ST_SEND: if (i_bank_data_ready) state_q <= ST_IDLE;
            ST_RECV: if (i_bank_rdata_valid) begin
               rsp_data_q <= i_bank_rdata;
               state_q    <= ST_RESP;
            end
            ST_RESP: if (i_rsp_ready) state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Illegal drops are counted independently of FIFO/FSM activity.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         illegal_q <= '0;
      end else if (req_fire && !legal && (illegal_q != 16'hFFFF)) begin
         illegal_q <= illegal_q + 16'd1;
      end
   end

   assign o_bank_request_type = (state_q == ST_IDLE) ? 4'b0000 : active_q.req_type;
   assign o_bank_addr         = active_q.addr;
   assign o_bank_data         = active_q.data;
   assign o_bank_data_valid   = (state_q == ST_SEND);
   assign o_bank_rdata_ready  = (state_q == ST_RECV);
   assign o_rsp_valid         = (state_q == ST_RESP);
   assign o_rsp_type          = o_rsp_valid ? active_q.req_type : 4'b0000;
   assign o_rsp_data          = rsp_data_q;
   assign o_illegal_count     = illegal_q;

endmodule

// File: tb/tb_fiber_bank_dispatch.sv
// Directed bench for fiber_bank_dispatch; inputs driven and outputs sampled on the falling edge.
module tb_fiber_bank_dispatch;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_type;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data;
   logic [3:0]    bank_type;
   logic [AW-1:0] bank_addr;
   logic [DW-1:0] bank_data;
   logic          bank_data_valid;
   logic          bank_data_ready;
   logic [DW-1:0] bank_rdata;
   logic          bank_rdata_valid;
   logic          bank_rdata_ready;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [3:0]    rsp_type;
   logic [DW-1:0] rsp_data;
   logic [15:0]   illegal_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fiber_bank_dispatch #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (4)
   ) dut (
      .i_clk               (clk),
      .i_reset             (rst),
      .i_req_valid         (req_valid),
      .o_req_ready         (req_ready),
      .i_req_type          (req_type),
      .i_req_addr          (req_addr),
      .i_req_data          (req_data),
      .o_bank_request_type (bank_type),
      .o_bank_addr         (bank_addr),
      .o_bank_data         (bank_data),
      .o_bank_data_valid   (bank_data_valid),
      .i_bank_data_ready   (bank_data_ready),
      .i_bank_rdata        (bank_rdata),
      .i_bank_rdata_valid  (bank_rdata_valid),
      .o_bank_rdata_ready  (bank_rdata_ready),
      .o_rsp_valid         (rsp_valid),
      .i_rsp_ready         (rsp_ready),
      .o_rsp_type          (rsp_type),
      .o_rsp_data          (rsp_data),
      .o_illegal_count     (illegal_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Presents one request for exactly one clock edge; returns on the following falling edge.
   task automatic send(input logic [3:0] t, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid = 1'b1;
      req_type  = t;
      req_addr  = a;
      req_data  = d;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      logic [3:0] bad_types [3];
      int         idx;
      logic       seen;

      rst              = 1'b1;
      req_valid        = 1'b0;
      req_type         = 4'b0000;
      req_addr         = '0;
      req_data         = '0;
      bank_data_ready  = 1'b0;
      bank_rdata       = '0;
      bank_rdata_valid = 1'b0;
      rsp_ready        = 1'b0;

      tick();
      check("rst_req_ready", req_ready, 1);
      check("rst_bank_type", bank_type, 0);
      check("rst_bank_addr", bank_addr, 0);
      check("rst_data_valid", bank_data_valid, 0);
      check("rst_rdata_ready", bank_rdata_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_illegal", illegal_count, 0);
      rst = 1'b0;
      tick();

      // single write with 3 cycles of bank backpressure
      send(4'b0100, 64'h1230, 16'hBEEF);
      check("wr_still_idle", bank_type, 4'b0000);
      tick();
      for (int c = 0; c < 3; c++) begin
         check("wr_type", bank_type, 4'b0100);
         check("wr_addr", bank_addr, 64'h1230);
         check("wr_data", bank_data, 16'hBEEF);
         check("wr_valid", bank_data_valid, 1);
         if (c < 2) tick();
      end
      bank_data_ready = 1'b1;
      tick();
      bank_data_ready = 1'b0;
      check("wr_done_type", bank_type, 4'b0000);
      check("wr_done_valid", bank_data_valid, 0);

      // read round trip
      send(4'b0010, 64'h40, 16'h0);
      tick();
      check("rd_type", bank_type, 4'b0010);
      check("rd_addr", bank_addr, 64'h40);
      check("rd_rdata_ready", bank_rdata_ready, 1);
      repeat (3) tick();
      check("rd_wait_ready", bank_rdata_ready, 1);
      check("rd_wait_rsp", rsp_valid, 0);
      bank_rdata       = 16'h5A5A;
      bank_rdata_valid = 1'b1;
      tick();
      bank_rdata_valid = 1'b0;
      bank_rdata       = 16'h0000;
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_data, 16'h5A5A);
      check("rsp_type", rsp_type, 4'b0010);
      check("rsp_rdata_ready", bank_rdata_ready, 0);
      tick();
      check("rsp_hold_valid", rsp_valid, 1);
      check("rsp_hold_data", rsp_data, 16'h5A5A);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_released", rsp_valid, 0);
      check("rsp_type_idle", rsp_type, 4'b0000);

      // fill: one active write plus four queued
      for (int i = 0; i < 5; i++) begin
         check("fill_ready", req_ready, 1);
         req_valid = 1'b1;
         req_type  = 4'b0100;
         req_addr  = 64'(i);
         req_data  = 16'h0100 + 16'(i);
         tick();
      end
      check("full_ready", req_ready, 0);
      req_addr = 64'd5;
      req_data = 16'h0105;
      tick();
      req_valid = 1'b0;
      check("full_no_illegal", illegal_count, 0);
      bank_data_ready = 1'b1;
      idx = 0;
      for (int c = 0; c < 40 && idx < 5; c++) begin
         if (bank_data_valid) begin
            check("drain_addr", bank_addr, 64'(idx));
            check("drain_data", bank_data, 64'(16'h0100 + 16'(idx)));
            idx++;
         end
         tick();
      end
      check("drain_count", 64'(idx), 5);
      repeat (3) tick();
      check("drain_quiet", bank_data_valid, 0);
      check("drain_ready", req_ready, 1);
      bank_data_ready = 1'b0;

      // illegal encodings, then one CONSUME
      bad_types[0] = 4'b0000;
      bad_types[1] = 4'b0011;
      bad_types[2] = 4'b1100;
      for (int i = 0; i < 3; i++) begin
         send(bad_types[i], 64'h99, 16'h9999);
         check("ill_not_issued", bank_type, 4'b0000);
      end
      send(4'b1000, 64'h77, 16'h0);
      check("ill_count3", illegal_count, 3);
      tick();
      check("cons_type", bank_type, 4'b1000);
      check("cons_addr", bank_addr, 64'h77);
      bank_rdata       = 16'h1111;
      bank_rdata_valid = 1'b1;
      rsp_ready        = 1'b1;
      tick();
      bank_rdata_valid = 1'b0;
      check("cons_rsp_valid", rsp_valid, 1);
      check("cons_rsp_type", rsp_type, 4'b1000);
      check("cons_rsp_data", rsp_data, 16'h1111);
      tick();
      rsp_ready = 1'b0;
      check("cons_done", rsp_valid, 0);

      // drive the counter to saturation
      req_valid = 1'b1;
      req_type  = 4'b0110;
      repeat (65531) tick();
      check("sat_fffe", illegal_count, 16'hFFFE);
      tick();
      check("sat_ffff", illegal_count, 16'hFFFF);
      tick();
      check("sat_hold", illegal_count, 16'hFFFF);
      req_valid = 1'b0;

      // reset while a read is outstanding with two writes queued
      send(4'b0010, 64'h100, 16'h0);
      send(4'b0100, 64'h200, 16'h2222);
      send(4'b0100, 64'h300, 16'h3333);
      check("mid_recv_type", bank_type, 4'b0010);
      check("mid_recv_ready", bank_rdata_ready, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_type", bank_type, 4'b0000);
      check("arst_addr", bank_addr, 0);
      check("arst_rdata_ready", bank_rdata_ready, 0);
      check("arst_rsp_valid", rsp_valid, 0);
      check("arst_req_ready", req_ready, 1);
      check("arst_illegal", illegal_count, 0);
      tick();
      rst              = 1'b0;
      bank_rdata       = 16'hDEAD;
      bank_rdata_valid = 1'b1;
      seen             = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         seen = seen | rsp_valid | bank_rdata_ready | bank_data_valid | (bank_type != 4'b0000);
      end
      bank_rdata_valid = 1'b0;
      check("post_rst_quiet", seen, 0);
      send(4'b0100, 64'h500, 16'h5555);
      tick();
      check("post_rst_first_type", bank_type, 4'b0100);
      check("post_rst_first_addr", bank_addr, 64'h500);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
